// File: rtl/fp_sum_module.sv
// fp_sum_module: pipelined 16-input single-precision adder tree with optional accumulate (FP_SUM_ACC_EN)
module fp_sum_module #(
   parameter logic [3:0] latency = 4'd5
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_11_A,
   input  logic [31:0] in_11_B,
   input  logic [31:0] in_12_A,
   input  logic [31:0] in_12_B,
   input  logic [31:0] in_13_A,
   input  logic [31:0] in_13_B,
   input  logic [31:0] in_14_A,
   input  logic [31:0] in_14_B,
   input  logic [31:0] in_15_A,
   input  logic [31:0] in_15_B,
   input  logic [31:0] in_16_A,
   input  logic [31:0] in_16_B,
   input  logic [31:0] in_17_A,
   input  logic [31:0] in_17_B,
   input  logic [31:0] in_18_A,
   input  logic [31:0] in_18_B,
   input  logic        acc_sign,
   input  logic [31:0] custom_last,
   input  logic        en_custom_last,
   input  logic        clock_en,
   input  logic        save_sign,
   output logic [31:0] result_all
);
   localparam int NDLY = (latency < 4'd5) ? 0 : int'(latency) - 5;

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic        an, bn, ai, bi, az, bz;
      logic [26:0] mx, my, m;
      logic [27:0] s;
      logic [49:0] sh;
      logic [24:0] mr;
      int          d, e, lz;
      an = (&a[30:23]) && (|a[22:0]);
      bn = (&b[30:23]) && (|b[22:0]);
      ai = (&a[30:23]) && !(|a[22:0]);
      bi = (&b[30:23]) && !(|b[22:0]);
      az = ~|a[30:23];
      bz = ~|b[30:23];
      if (an || bn) return 32'h7FC00000;
      if (ai && bi) return (a[31] == b[31]) ? a : 32'h7FC00000;
      if (ai) return a;
      if (bi) return b;
      if (az && bz) return '0;
      if (az) return b;
      if (bz) return a;
      {x, y} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
      d  = int'(x[30:23]) - int'(y[30:23]);
      e  = int'(x[30:23]);
      mx = {1'b1, x[22:0], 3'b000};
      sh = {1'b1, y[22:0], 26'd0} >> d;
      my = (d >= 26) ? 27'd1 : {sh[49:24], |sh[23:0]};
      if (x[31] == y[31]) begin
         s = {1'b0, mx} + {1'b0, my};
         if (s[27]) begin
            m = {s[27:2], s[1] | s[0]};
            e = e + 1;
         end else m = s[26:0];
      end else begin
         s = {1'b0, mx} - {1'b0, my};
         if (s == '0) return '0;
         lz = 0;
         for (int i = 0; i <= 26; i++) if (s[i]) lz = 26 - i;
         m = s[26:0] << lz;
         e = e - lz;
      end
      // round to nearest even on guard bit with round/sticky below it
      mr = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
      e  = e + int'(mr[24]);
      if (e >= 255) return {x[31], 8'hFF, 23'd0};
      if (e <= 0) return '0;
      return {x[31], e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
   endfunction

   logic [31:0] ina [16];
   logic [31:0] s1 [8];
   logic [31:0] s2 [4];
   logic [31:0] s3 [2];
   logic [31:0] s4, s5, s5_d;

   assign ina = '{in_11_A, in_11_B, in_12_A, in_12_B, in_13_A, in_13_B, in_14_A, in_14_B,
                  in_15_A, in_15_B, in_16_A, in_16_B, in_17_A, in_17_B, in_18_A, in_18_B};

   // Adder tree: one registered level per stage, stage5 holds the (optionally accumulated) sum
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < 8; i++) s1[i] <= '0;
         for (int i = 0; i < 4; i++) s2[i] <= '0;
         for (int i = 0; i < 2; i++) s3[i] <= '0;
         s4 <= '0;
         s5 <= '0;
      end else if (clock_en) begin
         for (int i = 0; i < 8; i++) s1[i] <= fp_add(ina[2*i], ina[2*i+1]);
         for (int i = 0; i < 4; i++) s2[i] <= fp_add(s1[2*i], s1[2*i+1]);
         for (int i = 0; i < 2; i++) s3[i] <= fp_add(s2[2*i], s2[2*i+1]);
         s4 <= fp_add(s3[0], s3[1]);
         s5 <= s5_d;
      end
   end

`ifdef FP_SUM_ACC_EN
   logic [3:0]  acc_p, en_p, save_p;
   logic [31:0] cl_p [4];
   logic [31:0] last_reg, base;

   assign base = en_p[3] ? cl_p[3] : last_reg;
   assign s5_d = acc_p[3] ? fp_add(s4, base) : s4;

   // Controls ride alongside the tree so they meet their own sample at stage5; last_reg keeps saved results
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_p    <= '0;
         en_p     <= '0;
         save_p   <= '0;
         for (int i = 0; i < 4; i++) cl_p[i] <= '0;
         last_reg <= '0;
      end else if (clock_en) begin
         acc_p   <= {acc_p[2:0], acc_sign};
         en_p    <= {en_p[2:0], en_custom_last};
         save_p  <= {save_p[2:0], save_sign};
         cl_p[0] <= custom_last;
         for (int i = 1; i < 4; i++) cl_p[i] <= cl_p[i-1];
         if (save_p[3]) last_reg <= s5_d;
      end
   end
`else
   logic unused_ctrl;
   assign unused_ctrl = ^{acc_sign, en_custom_last, custom_last, save_sign};
   assign s5_d = s4;
`endif

   generate
      if (NDLY == 0) begin : g_nodly
         assign result_all = s5;
      end else begin : g_dly
         logic [31:0] dly [NDLY];
         // Extra delay stages stretch the total latency to the configured value
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               for (int i = 0; i < NDLY; i++) dly[i] <= '0;
            end else if (clock_en) begin
               dly[0] <= s5;
               for (int i = 1; i < NDLY; i++) dly[i] <= dly[i-1];
            end
         end
         assign result_all = dly[NDLY-1];
      end
   endgenerate
endmodule

// File: tb/tb_fp_sum_module.sv
// tb_fp_sum_module: scoreboard bench for fp_sum_module
module tb_fp_sum_module;
   localparam logic [3:0] LAT = 4'd5;

   typedef struct {
      logic [31:0] val;
      int          tol;
      int          due;
   } sb_t;

   logic        aclk = 1'b0, aresetn = 1'b1, acc_sign = 1'b0, en_custom_last = 1'b0;
   logic        clock_en = 1'b0, save_sign = 1'b0;
   logic [31:0] custom_last = '0, result_all;
   logic [31:0] din [16];
   int          n_chk = 0, n_pass = 0, ecyc = 0;
   sb_t         sbq [$];

   fp_sum_module #(.latency(LAT)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .in_11_A(din[0]),  .in_11_B(din[1]),  .in_12_A(din[2]),  .in_12_B(din[3]),
      .in_13_A(din[4]),  .in_13_B(din[5]),  .in_14_A(din[6]),  .in_14_B(din[7]),
      .in_15_A(din[8]),  .in_15_B(din[9]),  .in_16_A(din[10]), .in_16_B(din[11]),
      .in_17_A(din[12]), .in_17_B(din[13]), .in_18_A(din[14]), .in_18_B(din[15]),
      .acc_sign(acc_sign), .custom_last(custom_last), .en_custom_last(en_custom_last),
      .clock_en(clock_en), .save_sign(save_sign), .result_all(result_all)
   );

   initial forever #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol = 0);
      longint diff;
      diff = longint'(obs) - longint'(exp);
      n_chk++;
      if ((tol == 0) ? (obs === exp) : (diff <= tol && diff >= -tol)) n_pass++;
      else $display("FAIL %s: got %08h, want %08h (tol %0d ulp) at %0t", tag, obs, exp, tol, $time);
   endtask

   function automatic logic [31:0] to_sp(input real r);
      logic [63:0] d;
      logic [23:0] mr;
      int          e;
      if (r == 0.0) return '0;
      d  = $realtobits(r);
      e  = int'(d[62:52]) - 1023 + 127;
      mr = {1'b0, d[51:29]} + 24'(d[28] & ((|d[27:0]) | d[29]));
      e  = e + int'(mr[23]);
      return {d[63], e[7:0], mr[22:0]};
   endfunction

   function automatic real to_real(input logic [31:0] b);
      logic [10:0] e;
      if (b[30:23] == 8'd0) return 0.0;
      e = 11'(int'(b[30:23]) - 127 + 1023);
      return $bitstoreal({b[31], e, b[22:0], 29'd0});
   endfunction

   task automatic set_all(input logic [31:0] v);
      for (int i = 0; i < 16; i++) din[i] = v;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 16; i++) din[i] = to_sp(real'(i + 1));
   endtask

   task automatic set_hund(output logic [31:0] exp);
      real s, v;
      s = 0.0;
      for (int i = 0; i < 16; i++) begin
         v = (i < 9) ? (i + 1) * 1.1 : (i + 1) + (i + 1) / 100.0;
         din[i] = to_sp(v);
         s += to_real(din[i]);
      end
      exp = to_sp(s);
   endtask

   // call at a falling edge: the next rising edge samples the current inputs
   task automatic send(input logic [31:0] exp, input int tol = 0);
      sbq.push_back('{exp, tol, ecyc + int'(LAT)});
      clock_en = 1'b1;
      @(negedge aclk);
   endtask

   task automatic hold(input int n);
      logic [31:0] v;
      clock_en = 1'b0;
      v = result_all;
      for (int i = 0; i < 16; i++) din[i] = $urandom;
      repeat (n) begin
         @(negedge aclk);
         check("frozen", result_all, v);
      end
   endtask

   initial begin
      sb_t e;
      forever begin
         @(posedge aclk);
         if (aresetn && clock_en) ecyc++;
         #1;
         while (sbq.size() > 0 && sbq[0].due <= ecyc) begin
            e = sbq.pop_front();
            check("pipe", result_all, e.val, e.tol);
         end
      end
   end

   initial begin
      logic [31:0] hexp;
      int          sum;
      set_all('0);
      #1 aresetn = 1'b0;
      #1 check("reset", result_all, 32'h0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;

      set_ramp();
      send(32'h43080000);
      set_hund(hexp);
      send(hexp, 4);
      set_all('0);
      din[0] = 32'h7F800000;
      din[2] = 32'hFF800000;
      send(32'h7FC00000);
      set_all('0);
      send(32'h00000000);
      din[0] = 32'h7F7FFFFF;
      din[1] = 32'h7F7FFFFF;
      send(32'h7F800000);
      set_all(32'h3F800000);
      din[4] = 32'hFF800000;
      send(32'hFF800000);
      set_all('0);
      din[9] = 32'h7F800001;
      send(32'h7FC00000);
      for (int i = 0; i < 16; i++) din[i] = i[0] ? 32'h80000001 : 32'h00000001;
      send(32'h00000000);
      set_all('0);
      din[0] = 32'h3F800000;
      din[1] = 32'hBF800000;
      send(32'h00000000);

      set_ramp();
      acc_sign = 1'b1;
      en_custom_last = 1'b1;
      custom_last = 32'h41200000;
      save_sign = 1'b1;
`ifdef FP_SUM_ACC_EN
      send(32'h43120000);
      en_custom_last = 1'b0;
      save_sign = 1'b0;
      send(32'h438D0000);
      set_all('0);
      send(32'h43120000);
`else
      send(32'h43080000);
      en_custom_last = 1'b0;
      save_sign = 1'b0;
      send(32'h43080000);
      set_all('0);
      send(32'h00000000);
`endif
      acc_sign = 1'b0;
      custom_last = '0;

      set_ramp();
      send(32'h43080000);
      hold(3);
      set_hund(hexp);
      send(hexp, 4);
      hold(2);
      set_ramp();
      send(32'h43080000);

      for (int n = 0; n < 24; n++) begin
         sum = 0;
         for (int i = 0; i < 16; i++) begin
            int v;
            v = int'($urandom_range(2000)) - 1000;
            din[i] = to_sp(real'(v));
            sum += v;
         end
         send(to_sp(real'(sum)));
         if ($urandom_range(3) == 0) hold(int'($urandom_range(3, 1)));
      end

      set_ramp();
      repeat (int'(LAT) + 2) send(32'h43080000);
      #2 aresetn = 1'b0;
      #1 check("rst_async", result_all, 32'h0);
      sbq.delete();
      @(negedge aclk);
      check("rst_low", result_all, 32'h0);
      aresetn = 1'b1;
      send(32'h43080000);
      check("rst_hold", result_all, 32'h0);
      set_all('0);
      for (int k = 0; k < int'(LAT) - 2; k++) begin
         send(32'h0);
         check("rst_hold", result_all, 32'h0);
      end

      set_all('0);
      clock_en = 1'b1;
      repeat (int'(LAT) + 1) @(negedge aclk);
      check("drain", 32'(sbq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
